// File: rtl/dmem_responder.sv
// dmem_responder: same-cycle data-memory responder for the single-cycle MIPS core (RAM + GPIO/timer MMIO page).
// Optional timer block (TCOUNT/TCMP/TCTRL/TSTAT, irq) is compiled in when DMEM_TIMER_EN is defined.
module dmem_responder #(
  parameter int unsigned RAM_AW = 6,
  parameter int unsigned GPIO_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memwrite,
  input  logic [31:0]       memaddr,
  input  logic [31:0]       memwritedata,
  output logic [31:0]       memreaddata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

  // MMIO register word offsets (memaddr[7:2])
  localparam logic [5:0] OFS_GPIO_OUT = 6'h00;
  localparam logic [5:0] OFS_GPIO_IN  = 6'h01;
`ifdef DMEM_TIMER_EN
  localparam logic [5:0] OFS_TCOUNT   = 6'h02;
  localparam logic [5:0] OFS_TCMP     = 6'h03;
  localparam logic [5:0] OFS_TCTRL    = 6'h04;
  localparam logic [5:0] OFS_TSTAT    = 6'h05;
`endif

  // Address decode
  logic              is_mmio;
  logic              page_ok;
  logic [5:0]        reg_sel;
  logic              mmio_we;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_idx;

  assign is_mmio = (memaddr[31:16] == 16'hFFFF);
  assign page_ok = (memaddr[15:8] == 8'h00);
  assign reg_sel = memaddr[7:2];
  assign mmio_we = memwrite & is_mmio & page_ok;
  assign ram_we  = memwrite & ~is_mmio;
  assign ram_idx = memaddr[RAM_AW+1:2];

  // Byte-address bits [1:0] are ignored by design
  logic unused_ok;
  assign unused_ok = ^{memaddr[1:0], memwritedata};

  // Word RAM, contents not reset
  logic [31:0] ram [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= memwritedata;
  end

  // GPIO: output register and 2-flop input synchronizer
  logic [GPIO_W-1:0] gpio_s1;
  logic [GPIO_W-1:0] gpio_s2;
  logic              we_gpio_out;

  assign we_gpio_out = mmio_we && (reg_sel == OFS_GPIO_OUT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_out <= '0;
      gpio_s1  <= '0;
      gpio_s2  <= '0;
    end else begin
      gpio_s1 <= gpio_in;
      gpio_s2 <= gpio_s1;
      if (we_gpio_out) gpio_out <= memwritedata[GPIO_W-1:0];
    end
  end

`ifdef DMEM_TIMER_EN
  // Compare-match timer; core writes override the increment, match set beats W1C
  logic [31:0] tcount, tcount_nx;
  logic [31:0] tcmp, tcmp_nx;
  logic [2:0]  tctrl, tctrl_nx;
  logic        flag, flag_nx;
  logic        match;
  logic        we_tcount, we_tcmp, we_tctrl, we_tstat;

  assign we_tcount = mmio_we && (reg_sel == OFS_TCOUNT);
  assign we_tcmp   = mmio_we && (reg_sel == OFS_TCMP);
  assign we_tctrl  = mmio_we && (reg_sel == OFS_TCTRL);
  assign we_tstat  = mmio_we && (reg_sel == OFS_TSTAT);

  always_comb begin
    tcount_nx = tcount;
    tcmp_nx   = tcmp;
    tctrl_nx  = tctrl;
    flag_nx   = flag;
    match     = 1'b0;
    if (tctrl[0]) begin
      match     = (tcount == tcmp);
      tcount_nx = (match && tctrl[1]) ? 32'd0 : tcount + 32'd1;
    end
    if (we_tcount) tcount_nx = memwritedata;
    if (we_tcmp)   tcmp_nx   = memwritedata;
    if (we_tctrl)  tctrl_nx  = memwritedata[2:0];
    if (we_tstat && memwritedata[0]) flag_nx = 1'b0;
    if (match) flag_nx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tcount <= '0;
      tcmp   <= '0;
      tctrl  <= '0;
      flag   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      tcount <= tcount_nx;
      tcmp   <= tcmp_nx;
      tctrl  <= tctrl_nx;
      flag   <= flag_nx;
      irq    <= flag_nx & tctrl_nx[2];
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Zero-latency load mux; unmapped offsets and unused bits read 0
  always_comb begin
    memreaddata = 32'd0;
    if (!is_mmio) begin
      memreaddata = ram[ram_idx];
    end else if (page_ok) begin
      case (reg_sel)
        OFS_GPIO_OUT: memreaddata = 32'(gpio_out);
        OFS_GPIO_IN:  memreaddata = 32'(gpio_s2);
`ifdef DMEM_TIMER_EN
        OFS_TCOUNT:   memreaddata = tcount;
        OFS_TCMP:     memreaddata = tcmp;
        OFS_TCTRL:    memreaddata = 32'(tctrl);
        OFS_TSTAT:    memreaddata = 32'(flag);
`endif
        default:      memreaddata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; timer scenarios run only when DMEM_TIMER_EN is defined.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_responder #(.RAM_AW(6), .GPIO_W(16)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
    .memwritedata(memwritedata), .memreaddata(memreaddata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memaddr = a; memwritedata = d; memwrite = 1'b1;
    cyc();
    memwrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    memaddr = a; memwrite = 1'b0;
    #1;
    d = memreaddata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0; memwrite = 1'b0; memaddr = 32'd0; memwritedata = 32'd0; gpio_in = 16'd0;
    cyc(); cyc();
    reset = 1'b1;
    n_cmp++; if (gpio_out !== 16'h0000) begin n_bad++; $display("FAIL rst_gpio_out got=%h exp=0000", gpio_out); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
    rd(32'hFFFF0000, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_rd_gpio_out got=%h exp=0", d); end
    rd(32'hFFFF0004, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_rd_gpio_in got=%h exp=0", d); end
`ifdef DMEM_TIMER_EN
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_tcount got=%h exp=0", d); end
    rd(32'hFFFF0010, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rst_tctrl got=%h exp=0", d); end
`endif
  endtask

  task automatic test_ram();
    logic [31:0] d;
    wr(32'h00000010, 32'hDEADBEEF);
    wr(32'h00000014, 32'h0BADF00D);
    rd(32'h00000010, d);
    n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ram_load got=%h exp=deadbeef", d); end
    rd(32'h00000013, d);
    n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ram_lowbits got=%h exp=deadbeef", d); end
    rd(32'h00000110, d);
    n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ram_alias got=%h exp=deadbeef", d); end
    cyc();
    rd(32'h00000014, d);
    n_cmp++; if (d !== 32'h0BADF00D) begin n_bad++; $display("FAIL ram_neighbor got=%h exp=0badf00d", d); end
  endtask

  task automatic test_rdw();
    wr(32'h00000020, 32'h00000001);
    memaddr = 32'h00000020; memwritedata = 32'h00000005; memwrite = 1'b1;
    #1;
    n_cmp++; if (memreaddata !== 32'h1) begin n_bad++; $display("FAIL rdw_old got=%h exp=00000001", memreaddata); end
    cyc();
    memwrite = 1'b0;
    #1;
    n_cmp++; if (memreaddata !== 32'h5) begin n_bad++; $display("FAIL rdw_new got=%h exp=00000005", memreaddata); end
  endtask

  task automatic test_gpio();
    logic [31:0] d;
    wr(32'hFFFF0000, 32'h0000A5A5);
    n_cmp++; if (gpio_out !== 16'hA5A5) begin n_bad++; $display("FAIL gpio_out got=%h exp=a5a5", gpio_out); end
    rd(32'hFFFF0000, d);
    n_cmp++; if (d !== 32'h0000A5A5) begin n_bad++; $display("FAIL gpio_out_rd got=%h exp=0000a5a5", d); end
    wr(32'hFFFF0100, 32'h00000000);
    n_cmp++; if (gpio_out !== 16'hA5A5) begin n_bad++; $display("FAIL gpio_badpage_wr got=%h exp=a5a5", gpio_out); end
    rd(32'hFFFF0100, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL unmapped_page got=%h exp=0", d); end
    rd(32'hFFFF0018, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL unmapped_ofs got=%h exp=0", d); end
    gpio_in = 16'h1234;
    rd(32'hFFFF0004, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL gpio_in_e0 got=%h exp=0", d); end
    cyc();
    rd(32'hFFFF0004, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL gpio_in_e1 got=%h exp=0", d); end
    cyc();
    rd(32'hFFFF0004, d);
    n_cmp++; if (d !== 32'h00001234) begin n_bad++; $display("FAIL gpio_in_e2 got=%h exp=00001234", d); end
  endtask

`ifdef DMEM_TIMER_EN
  task automatic test_timer_match();
    logic [31:0] d;
    wr(32'hFFFF000C, 32'd3);
    wr(32'hFFFF0010, 32'h7);
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL tm_start got=%h exp=0", d); end
    cyc(); cyc(); cyc();
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL tm_at3 got=%h exp=3", d); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL tm_irq_pre got=%b exp=0", irq); end
    cyc();
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL tm_autoclr got=%h exp=0", d); end
    rd(32'hFFFF0014, d);
    n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL tm_flag got=%h exp=1", d); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL tm_irq got=%b exp=1", irq); end
    wr(32'hFFFF0014, 32'd1);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL tm_w1c_irq got=%b exp=0", irq); end
    rd(32'hFFFF0014, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL tm_w1c_flag got=%h exp=0", d); end
    cyc(); cyc();
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL tm_at3b got=%h exp=3", d); end
    wr(32'hFFFF0014, 32'd1);
    rd(32'hFFFF0014, d);
    n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL tm_set_wins got=%h exp=1", d); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL tm_set_wins_irq got=%b exp=1", irq); end
    wr(32'hFFFF0014, 32'd0);
    rd(32'hFFFF0014, d);
    n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL tm_w0_noeffect got=%h exp=1", d); end
  endtask

  task automatic test_wrap_priority();
    logic [31:0] d;
    wr(32'hFFFF000C, 32'd5);
    wr(32'hFFFF0008, 32'hFFFFFFFE);
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL wr_tcount got=%h exp=fffffffe", d); end
    cyc();
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL wrap_ff got=%h exp=ffffffff", d); end
    cyc();
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'h00000000) begin n_bad++; $display("FAIL wrap_0 got=%h exp=0", d); end
    wr(32'hFFFF0008, 32'h100);
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'h100) begin n_bad++; $display("FAIL wr_wins got=%h exp=100", d); end
    cyc();
    wr(32'hFFFF0010, 32'hFFFFFFF8);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irqen_clr got=%b exp=0", irq); end
    rd(32'hFFFF0010, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL tctrl_narrow got=%h exp=0", d); end
    cyc(); cyc();
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'h102) begin n_bad++; $display("FAIL disabled_hold got=%h exp=102", d); end
  endtask
`else
  task automatic test_no_timer();
    logic [31:0] d;
    wr(32'hFFFF0008, 32'h55);
    wr(32'hFFFF0010, 32'h7);
    cyc();
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL nt_tcount got=%h exp=0", d); end
    rd(32'hFFFF0010, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL nt_tctrl got=%h exp=0", d); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL nt_irq got=%b exp=0", irq); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
`ifdef DMEM_TIMER_EN
    wr(32'hFFFF0010, 32'h7);
`endif
    wr(32'hFFFF0000, 32'h0000FFFF);
    n_cmp++; if (gpio_out !== 16'hFFFF) begin n_bad++; $display("FAIL rm_gpio_pre got=%h exp=ffff", gpio_out); end
`ifdef DMEM_TIMER_EN
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL rm_irq_pre got=%b exp=1", irq); end
`endif
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    n_cmp++; if (gpio_out !== 16'h0000) begin n_bad++; $display("FAIL rm_gpio got=%h exp=0000", gpio_out); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rm_irq got=%b exp=0", irq); end
    rd(32'hFFFF0000, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rm_rd_gpio got=%h exp=0", d); end
`ifdef DMEM_TIMER_EN
    cyc();
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rm_tcount got=%h exp=0", d); end
    rd(32'hFFFF000C, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rm_tcmp got=%h exp=0", d); end
    rd(32'hFFFF0014, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rm_tstat got=%h exp=0", d); end
`else
    rd(32'hFFFF0008, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL rm_nt_tcount got=%h exp=0", d); end
`endif
    rd(32'h00000010, d);
    n_cmp++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rm_ram_kept got=%h exp=deadbeef", d); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_rdw();
    test_gpio();
`ifdef DMEM_TIMER_EN
    test_timer_match();
    test_wrap_priority();
`else
    test_no_timer();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
